// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the TinyTone melody sequencer: state encodings, tempo codes, gap defaults.
package melody_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    // tempo_sel codes: beats per note minus one
    localparam logic [1:0] TEMPO_1 = 2'd0;
    localparam logic [1:0] TEMPO_2 = 2'd1;
    localparam logic [1:0] TEMPO_3 = 2'd2;
    localparam logic [1:0] TEMPO_4 = 2'd3;

    // Default articulation gap is 19.2 periods of the 125-cycle PWM carrier (2400 cycles)
    localparam int unsigned PWM_PERIOD         = 125;
    localparam int unsigned DEFAULT_GAP_CYCLES = (PWM_PERIOD * 96) / 5;

    // Gap counter load value; a zero-length gap still costs one cycle
    function automatic int unsigned gap_load_value(input int unsigned gap_cycles);
        return (gap_cycles > 1) ? (gap_cycles - 1) : 0;
    endfunction

endpackage

// File: rtl/melody_sequencer_note_gap_timer.sv
// Loadable down-counter that times the silent gap between notes; saturates at zero.
module note_gap_timer #(
    parameter int unsigned GAP_BW = 16
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              load_i,
    input  logic [GAP_BW-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_c
);

    logic [GAP_BW-1:0] cnt_q;
    logic [GAP_BW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - GAP_BW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Playback controller: steps the notes-ROM index on beat strobes with play/stop/loop control,
// a latched note length and an articulation gap between notes.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned IDX_BW     = 6,
    parameter int unsigned SEQ_LEN    = 64,
    parameter int unsigned GAP_BW     = 16,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              strb_i,
    input  logic              play_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [1:0]        tempo_sel_i,
    output logic [IDX_BW-1:0] note_index_o,
    output logic              note_on_o,
    output logic              note_gate_o,
    output logic              playing_o,
    output logic              seq_done_o
);

    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(SEQ_LEN - 1);
    localparam logic [GAP_BW-1:0] GAP_LOAD = GAP_BW'(gap_load_value(GAP_CYCLES));

    seq_state_e        state_q, state_d;
    logic [IDX_BW-1:0] index_q, index_d;
    logic [1:0]        beat_cnt_q, beat_cnt_d;
    logic [1:0]        len_q, len_d;
    logic              note_on_q, note_on_d;
    logic              gate_q, gate_d;
    logic              playing_q, playing_d;
    logic              seq_done_q, seq_done_d;

    logic              enter_note;
    logic              gap_load;
    logic              gap_dec;
    logic              gap_zero;

    note_gap_timer #(
        .GAP_BW (GAP_BW)
    ) u_gap_timer (
        .clk_i      (clk_i),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_c     (gap_zero)
    );

    // Next-state, datapath updates and registered output values
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        enter_note = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (play_i && !stop_i) begin
                    state_d    = ST_NOTE;
                    index_d    = '0;
                    enter_note = 1'b1;
                end
            end
            ST_NOTE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (strb_i) begin
                    if (beat_cnt_q == len_q) begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (gap_zero) begin
                    if (index_q < LAST_IDX) begin
                        state_d    = ST_NOTE;
                        index_d    = index_q + IDX_BW'(1);
                        enter_note = 1'b1;
                    end else if (loop_i) begin
                        state_d    = ST_NOTE;
                        index_d    = '0;
                        enter_note = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Note length is captured only on entry so mid-note tempo changes wait for the next note
        if (enter_note) begin
            beat_cnt_d = '0;
            len_d      = tempo_sel_i;
        end

        note_on_d  = enter_note;
        gate_d     = (state_d == ST_NOTE);
        playing_d  = (state_d == ST_NOTE) || (state_d == ST_GAP);
        seq_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            note_on_q  <= 1'b0;
            gate_q     <= 1'b0;
            playing_q  <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            note_on_q  <= note_on_d;
            gate_q     <= gate_d;
            playing_q  <= playing_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign note_index_o = index_q;
    assign note_on_o    = note_on_q;
    assign note_gate_o  = gate_q;
    assign playing_o    = playing_q;
    assign seq_done_o   = seq_done_q;

endmodule
